// File: rtl/apb_spi_responder.sv
// apb_spi_responder: APB3 completer with an SPI-style register map.
// Bytes arrive on a side stream into an RX FIFO and leave from a TX FIFO.
// PREADY, PRDATA and PSLVERR are registered. The response is decided at the
// edge that raises PREADY. Side effects commit at the edge that ends it.
module apb_spi_responder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [1:0]    WS      = WAIT_STATES[1:0];

  localparam logic [7:0] ADDR_CONTROL  = 8'h00;
  localparam logic [7:0] ADDR_INTCLEAR = 8'h04;
  localparam logic [7:0] ADDR_RXDATA   = 8'h08;
  localparam logic [7:0] ADDR_TXDATA   = 8'h0C;
  localparam logic [7:0] ADDR_STATUS   = 8'h20;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0] state_q;
  logic [1:0] wait_cnt_q;
  logic [7:0] addr_q;
  logic       write_q;
  logic [7:0] wdata_q;
  logic       pready_q;
  logic       pslverr_q;
  logic [7:0] prdata_q;

  logic ctrl_en_q;
  logic ctrl_irqen_q;
  logic rx_ovf_q;
  logic tx_ovf_q;
  logic irq_q;

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [PW-1:0] tx_wr_ptr, tx_rd_ptr;

  // FIFO occupancy from the pointers. The extra MSB separates full from empty.
  logic rx_empty, rx_full, tx_empty, tx_full;
  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full  = (rx_wr_ptr[AW] != rx_rd_ptr[AW]) &&
                    (rx_wr_ptr[AW-1:0] == rx_rd_ptr[AW-1:0]);
  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = (tx_wr_ptr[AW] != tx_rd_ptr[AW]) &&
                    (tx_wr_ptr[AW-1:0] == tx_rd_ptr[AW-1:0]);

  logic [7:0] status;
  assign status = {1'b0, ctrl_en_q, tx_ovf_q, rx_ovf_q,
                   tx_full, tx_empty, rx_full, !rx_empty};

  // Setup-cycle detection. With zero wait states the response is decided at
  // the setup edge itself, before the request has been latched.
  logic       setup_start;
  logic       resp_write;
  logic [7:0] resp_addr;
  assign setup_start = (state_q == ST_IDLE) && PSEL && !PENABLE;
  assign resp_addr   = (state_q == ST_IDLE) ? PADDR  : addr_q;
  assign resp_write  = (state_q == ST_IDLE) ? PWRITE : write_q;

  // Response decode: error flag and read data for the addressed register.
  logic       resp_err;
  logic [7:0] resp_data;
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    resp_err  = 1'b0;
    resp_data = 8'h00;
    case (resp_addr)
      ADDR_CONTROL:  if (!resp_write) resp_data = {6'b0, ctrl_irqen_q, ctrl_en_q};
      ADDR_INTCLEAR: resp_err = !resp_write;
      ADDR_RXDATA: begin
        if (resp_write || rx_empty) resp_err = 1'b1;
        else                        resp_data = rx_mem[rx_rd_ptr[AW-1:0]];
      end
      ADDR_TXDATA:   resp_err = !resp_write || tx_full;
      ADDR_STATUS: begin
        if (resp_write) resp_err = 1'b1;
        else            resp_data = status;
      end
      default:       resp_err = 1'b1;
    endcase
  end

  // Commit strobes, qualified by the error decision registered with PREADY.
  logic commit, c_write, c_read;
  logic apb_rx_pop, apb_tx_push, ctrl_wr, flush, intclr, tx_ovf_set;
  assign commit      = (state_q == ST_ACCESS) && pready_q && PSEL;
  assign c_write     = commit && write_q && !pslverr_q;
  assign c_read      = commit && !write_q && !pslverr_q;
  assign apb_rx_pop  = c_read  && (addr_q == ADDR_RXDATA);
  assign apb_tx_push = c_write && (addr_q == ADDR_TXDATA);
  assign ctrl_wr     = c_write && (addr_q == ADDR_CONTROL);
  assign intclr      = c_write && (addr_q == ADDR_INTCLEAR);
  assign flush       = ctrl_wr && wdata_q[2];
  assign tx_ovf_set  = commit && write_q && pslverr_q && (addr_q == ADDR_TXDATA);

  // Side-stream handshakes. A pop of a full RX FIFO in the same cycle frees a slot.
  logic rx_push_req, rx_push, rx_ovf_set, tx_pop;
  assign rx_push_req = rx_valid && ctrl_en_q;
  assign rx_push     = rx_push_req && (!rx_full || apb_rx_pop);
  assign rx_ovf_set  = rx_push_req && rx_full && !apb_rx_pop;
  assign tx_valid    = ctrl_en_q && !tx_empty;
  assign tx_data     = tx_mem[tx_rd_ptr[AW-1:0]];
  assign tx_pop      = tx_valid && tx_ready;

  logic unused_wdata_bits;
  assign unused_wdata_bits = ^{wdata_q[7:6], wdata_q[3]};

  // APB transfer FSM with registered PREADY/PRDATA/PSLVERR.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= ST_IDLE;
      wait_cnt_q <= 2'd0;
      addr_q     <= 8'h00;
      write_q    <= 1'b0;
      wdata_q    <= 8'h00;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= 8'h00;
    end else if (state_q == ST_IDLE) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 8'h00;
      if (setup_start) begin
        state_q    <= ST_ACCESS;
        wait_cnt_q <= WS;
        addr_q     <= PADDR;
        write_q    <= PWRITE;
        wdata_q    <= PWDATA;
        if (WS == 2'd0) begin
          pready_q  <= 1'b1;
          pslverr_q <= resp_err;
          prdata_q  <= resp_data;
        end
      end
    end else if (!PSEL || pready_q) begin
      state_q   <= ST_IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 8'h00;
    end else begin
      wait_cnt_q <= wait_cnt_q - 2'd1;
      if (wait_cnt_q == 2'd1) begin
        pready_q  <= 1'b1;
        pslverr_q <= resp_err;
        prdata_q  <= resp_data;
      end
    end
  end

  // CONTROL register and sticky overflow flags; a new overflow beats a clear.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      ctrl_en_q    <= 1'b0;
      ctrl_irqen_q <= 1'b0;
      rx_ovf_q     <= 1'b0;
      tx_ovf_q     <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl_en_q    <= wdata_q[0];
        ctrl_irqen_q <= wdata_q[1];
      end
      rx_ovf_q <= rx_ovf_set || (rx_ovf_q && !(intclr && wdata_q[4]));
      tx_ovf_q <= tx_ovf_set || (tx_ovf_q && !(intclr && wdata_q[5]));
    end
  end

  // FIFO pointers; FLUSH overrides any same-cycle push or pop.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else if (flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (rx_push)     rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (apb_rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      if (apb_tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)      tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
    end
  end

  // FIFO storage writes.
  always_ff @(posedge PCLK) begin
    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    if (rx_push)     rx_mem[rx_wr_ptr[AW-1:0]] <= rx_data;
    if (apb_tx_push) tx_mem[tx_wr_ptr[AW-1:0]] <= wdata_q;
  end

  // Registered level interrupt, one cycle behind its causes.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) irq_q <= 1'b0;
    else          irq_q <= ctrl_irqen_q && (!rx_empty || rx_ovf_q || tx_ovf_q);
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_apb_spi_responder.sv
// Directed bench for apb_spi_responder: one instance with zero wait states,
// one with three. APB responses are compared against a scoreboard queue.
module tb_apb_spi_responder;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;
  } apb_exp_t;

  logic       PCLK, PRESETN;
  logic       psel, penable, pwrite, sel3;
  logic [7:0] paddr, pwdata;
  logic       tx_ready, rx_valid;
  logic [7:0] rx_data;

  logic [7:0] prdata0, prdata3, tx_data0, tx_data3;
  logic       pready0, pready3, pslverr0, pslverr3;
  logic       tx_valid0, tx_valid3, irq0, irq3;

  logic [7:0] cur_prdata;
  logic       cur_pready, cur_pslverr;
  assign cur_prdata  = sel3 ? prdata3  : prdata0;
  assign cur_pready  = sel3 ? pready3  : pready0;
  assign cur_pslverr = sel3 ? pslverr3 : pslverr0;

  apb_exp_t   apb_q[$];
  logic [7:0] tx_q[$];
  int n_compared   = 0;
  int n_mismatched = 0;

  apb_spi_responder #(.FIFO_DEPTH(4), .WAIT_STATES(0)) dut0 (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel && !sel3), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0),
    .PREADY(pready0), .PSLVERR(pslverr0), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq0)
  );

  apb_spi_responder #(.FIFO_DEPTH(4), .WAIT_STATES(3)) dut3 (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel && sel3), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata3),
    .PREADY(pready3), .PSLVERR(pslverr3), .tx_data(tx_data3), .tx_valid(tx_valid3),
    .tx_ready(1'b0), .rx_data(8'h00), .rx_valid(1'b0), .irq(irq3)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One APB transfer; starts and ends one time unit after a rising edge.
  // Optionally drives an RX side byte during the PREADY cycle (zero-wait DUT).
  task automatic apb(input logic on3, input logic wr, input logic [7:0] addr,
                     input logic [7:0] wdata, input logic [7:0] exp_data,
                     input logic exp_err, input string tag,
                     input logic inject = 1'b0, input logic [7:0] inj_data = 8'h00);
    apb_exp_t e;
    int cyc;
    e.data = exp_data;
    e.err  = exp_err;
    e.lat  = on3 ? 4 : 1;
    apb_q.push_back(e);
    sel3 = on3; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge PCLK); #1;
    penable = 1'b1;
    if (inject) begin
      rx_valid = 1'b1;
      rx_data  = inj_data;
    end
    cyc = 0;
    do begin
      @(negedge PCLK);
      cyc++;
    end while (!cur_pready && cyc < 16);
    e = apb_q.pop_front();
    check({tag, "_lat"},  32'(cyc),         32'(e.lat));
    check({tag, "_err"},  32'(cur_pslverr), 32'(e.err));
    check({tag, "_data"}, 32'(cur_prdata),  32'(e.data));
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
    if (inject) rx_valid = 1'b0;
  endtask

  task automatic tx_write(input logic [7:0] b, input logic exp_err, input string tag);
    if (!exp_err) tx_q.push_back(b);
    apb(1'b0, 1'b1, 8'h0C, b, 8'h00, exp_err, tag);
  endtask

  initial begin
    psel = 0; penable = 0; pwrite = 0; sel3 = 0; paddr = 0; pwdata = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    PRESETN = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_pready",  32'(pready0),   32'h0);
    check("rst_prdata",  32'(prdata0),   32'h0);
    check("rst_pslverr", 32'(pslverr0),  32'h0);
    check("rst_irq",     32'(irq0),      32'h0);
    check("rst_txvalid", 32'(tx_valid0), 32'h0);
    PRESETN = 1'b1;
    @(posedge PCLK); #1;

    // Status after reset: only tx_empty.
    apb(1'b0, 1'b0, 8'h20, 8'h00, 8'h04, 1'b0, "status_rst");

    // Enable with interrupts, stream two RX bytes.
    apb(1'b0, 1'b1, 8'h00, 8'h03, 8'h00, 1'b0, "ctrl_wr");
    rx_valid = 1'b1; rx_data = 8'hA5;
    @(posedge PCLK); #1;
    rx_data = 8'h5A;
    @(negedge PCLK);
    check("irq_lag", 32'(irq0), 32'h0);
    @(posedge PCLK); #1;
    rx_valid = 1'b0;
    @(negedge PCLK);
    check("irq_set", 32'(irq0), 32'h1);
    @(posedge PCLK); #1;
    apb(1'b0, 1'b0, 8'h08, 8'h00, 8'hA5, 1'b0, "rx_pop0");
    apb(1'b0, 1'b0, 8'h08, 8'h00, 8'h5A, 1'b0, "rx_pop1");
    @(posedge PCLK);
    @(negedge PCLK);
    check("irq_clr", 32'(irq0), 32'h0);
    @(posedge PCLK); #1;
    apb(1'b0, 1'b0, 8'h08, 8'h00, 8'h00, 1'b1, "rx_empty_rd");

    // Fill TX past its depth with the consumer stalled.
    tx_write(8'h11, 1'b0, "tx_w0");
    tx_write(8'h22, 1'b0, "tx_w1");
    tx_write(8'h33, 1'b0, "tx_w2");
    tx_write(8'h44, 1'b0, "tx_w3");
    tx_write(8'h55, 1'b1, "tx_w4_full");
    apb(1'b0, 1'b0, 8'h20, 8'h00, 8'h68, 1'b0, "status_txfull");
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_b;
      @(negedge PCLK);
      exp_b = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hXX;
      check($sformatf("tx_valid%0d", i), 32'(tx_valid0), 32'h1);
      check($sformatf("tx_data%0d", i),  32'(tx_data0),  32'(exp_b));
    end
    @(negedge PCLK);
    check("tx_drained", 32'(tx_valid0), 32'h0);
    @(posedge PCLK); #1;
    tx_ready = 1'b0;
    apb(1'b0, 1'b1, 8'h04, 8'h30, 8'h00, 1'b0, "intclr");
    apb(1'b0, 1'b0, 8'h20, 8'h00, 8'h44, 1'b0, "status_clr");

    // RX full; an APB pop and a side push commit on the same edge.
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'hB0 + 8'(i);
      @(posedge PCLK); #1;
    end
    rx_valid = 1'b0;
    apb(1'b0, 1'b0, 8'h20, 8'h00, 8'h47, 1'b0, "status_rxfull");
    apb(1'b0, 1'b0, 8'h08, 8'h00, 8'hB0, 1'b0, "rx_poppush", 1'b1, 8'h77);
    apb(1'b0, 1'b0, 8'h20, 8'h00, 8'h47, 1'b0, "status_noovf");
    apb(1'b0, 1'b0, 8'h08, 8'h00, 8'hB1, 1'b0, "rx_b1");
    apb(1'b0, 1'b0, 8'h08, 8'h00, 8'hB2, 1'b0, "rx_b2");
    apb(1'b0, 1'b0, 8'h08, 8'h00, 8'hB3, 1'b0, "rx_b3");
    apb(1'b0, 1'b0, 8'h08, 8'h00, 8'h77, 1'b0, "rx_77");
    apb(1'b0, 1'b0, 8'h20, 8'h00, 8'h44, 1'b0, "status_rxdone");

    // FLUSH empties both FIFOs and reads back as 0.
    apb(1'b0, 1'b1, 8'h0C, 8'h99, 8'h00, 1'b0, "tx_pre_flush");
    rx_valid = 1'b1; rx_data = 8'hC1;
    @(posedge PCLK); #1;
    rx_valid = 1'b0;
    apb(1'b0, 1'b0, 8'h20, 8'h00, 8'h41, 1'b0, "status_preflush");
    apb(1'b0, 1'b1, 8'h00, 8'h07, 8'h00, 1'b0, "flush_wr");
    apb(1'b0, 1'b0, 8'h00, 8'h00, 8'h03, 1'b0, "ctrl_rd");
    apb(1'b0, 1'b0, 8'h20, 8'h00, 8'h44, 1'b0, "status_flushed");

    // Overflow RX, leave two bytes in each FIFO, then reset mid-access.
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'hC0 + 8'(i);
      @(posedge PCLK); #1;
    end
    rx_valid = 1'b0;
    apb(1'b0, 1'b0, 8'h08, 8'h00, 8'hC0, 1'b0, "ovf_pop0");
    apb(1'b0, 1'b0, 8'h08, 8'h00, 8'hC1, 1'b0, "ovf_pop1");
    apb(1'b0, 1'b1, 8'h0C, 8'hD0, 8'h00, 1'b0, "tx_d0");
    apb(1'b0, 1'b1, 8'h0C, 8'hD1, 8'h00, 1'b0, "tx_d1");
    apb(1'b0, 1'b0, 8'h20, 8'h00, 8'h51, 1'b0, "status_prerst");
    sel3 = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h08;
    @(posedge PCLK); #1;
    penable = 1'b1;
    #1 PRESETN = 1'b0;
    #1;
    check("midrst_pready", 32'(pready0),  32'h0);
    check("midrst_prdata", 32'(prdata0),  32'h0);
    check("midrst_irq",    32'(irq0),     32'h0);
    psel = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    PRESETN = 1'b1;
    @(posedge PCLK); #1;
    apb(1'b0, 1'b0, 8'h20, 8'h00, 8'h04, 1'b0, "status_postrst");

    // Three wait states on the second instance.
    apb(1'b1, 1'b0, 8'h30, 8'h00, 8'h00, 1'b1, "ws3_unmapped");
    apb(1'b1, 1'b1, 8'h20, 8'hFF, 8'h00, 1'b1, "ws3_wr_status");
    apb(1'b1, 1'b0, 8'h20, 8'h00, 8'h04, 1'b0, "ws3_status");
    check("sb_empty", 32'(apb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/apb_spi_responder.md
Name: apb_spi_responder

Overview:
- APB3 completer (responder) exposing an SPI-style register map: CONTROL, INTCLEAR, RXDATA, TXDATA, STATUS.
- Sits on the far end of the PCLK APB bus from our APB initiator FSMs. Gives a bus-functional SPI peripheral model on-chip, for loopback and bring-up.
- Buffers bytes in an RX FIFO, filled from a byte-stream side port, and a TX FIFO, drained to a byte-stream side port.

Parameters:
- FIFO_DEPTH, 4, entries per FIFO; power of two, 2..16.
- WAIT_STATES, 0, extra access-phase cycles before PREADY; 0..3.

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESETN  in  1  reset, asynchronous, active-low
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable (access phase)
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  8  byte address
- PWDATA  in  8  write data
- PRDATA  out  8  read data; valid when PREADY=1 in a read access
- PREADY  out  1  transfer completes this cycle
- PSLVERR  out  1  error response; meaningful only with PREADY=1
- tx_data  out  8  head of TX FIFO
- tx_valid  out  1  CONTROL.EN & TX FIFO not empty
- tx_ready  in  1  consumer pops TX head when tx_valid & tx_ready
- rx_data  in  8  byte to push into RX FIFO
- rx_valid  in  1  push strobe, one byte per cycle
- irq  out  1  level interrupt, registered

Behaviour:
- Reset, async: PRDATA=0x00, PREADY=0, PSLVERR=0, irq=0, CONTROL=0x00, both FIFOs empty, sticky flags 0, FSM=IDLE.
- Register map:
  - 0x00 CONTROL, RW: bit0 EN, bit1 IRQEN, bit2 FLUSH (write-1, self-clearing, reads 0), others 0.
  - 0x04 INTCLEAR, WO: write 1 to bit4/bit5 clears RX_OVF/TX_OVF.
  - 0x08 RXDATA, RO: read pops RX FIFO.
  - 0x0C TXDATA, WO: write pushes TX FIFO.
  - 0x20 STATUS, RO: bit0 rx_not_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 RX_OVF, bit5 TX_OVF, bit6 EN.
- APB FSM: IDLE -> ACCESS on PSEL & !PENABLE (setup cycle).
  - At the setup edge, load wait counter = WAIT_STATES and latch PADDR/PWRITE/PWDATA.
  - PREADY is registered: asserts in access cycle number WAIT_STATES+1, for exactly one cycle, then FSM returns to IDLE.
  - WAIT_STATES=0 gives a zero-wait two-cycle APB transfer.
- Completion: PRDATA, PSLVERR and all side effects (pop, push, register write, flag clear) commit at the edge ending the PREADY=1 cycle.
- PRDATA is driven with PREADY and is 0x00 at all other times.
- PSLVERR=1 (with PREADY) on any of:
  - unmapped address;
  - write to RXDATA or STATUS;
  - read of INTCLEAR or TXDATA;
  - read of RXDATA with RX FIFO empty: PRDATA=0x00, no pop;
  - write of TXDATA with TX FIFO full: byte dropped, TX_OVF set.
  An errored write changes no register.
- PSEL dropped mid-access (protocol violation): FSM returns to IDLE, no side effect, PREADY stays 0.
- RX side: push when rx_valid & EN.
  - RX full and no simultaneous APB pop: byte dropped, RX_OVF set.
  - rx_valid while EN=0 is ignored and does not set RX_OVF.
- TX side: pop when tx_valid & tx_ready.
- Same-cycle pop+push on a FIFO: both occur, count unchanged, legal even when full (push accepted) or when count=1.
- FLUSH: empties both FIFOs at the commit edge. It overrides same-cycle side push/pop; sticky flags are unchanged.
- Flag clear vs. new overflow in the same cycle: set wins.
- irq, registered: irq = IRQEN & (rx_not_empty | RX_OVF | TX_OVF). Updates one cycle after the cause.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits with wrap-around; full/empty derived from pointer MSB compare.
- Reset asserted mid-transfer: immediate return to reset values; any in-flight transfer is discarded.

Test Plan:
- Reset, then read STATUS (WAIT_STATES=0) -> PREADY on 2nd cycle of the transfer, PRDATA=0x04, PSLVERR=0; irq=0.
- Write CONTROL=0x03, drive rx_data 0xA5, 0x5A on consecutive cycles -> irq=1 one cycle after the first push; RXDATA reads return 0xA5 then 0x5A; third read gives PSLVERR=1, PRDATA=0x00; irq=0 after the 2nd pop.
- EN=1, tx_ready=0, write TXDATA 0x11,0x22,0x33,0x44,0x55 (depth 4) -> fifth write PSLVERR=1, STATUS=0x68. Raise tx_ready -> tx_data 0x11..0x44 on 4 consecutive cycles, then tx_valid=0.
- RX FIFO full, APB RXDATA pop commits in the same cycle as rx_valid=1 with 0x77 -> no overflow, count stays 4, last read returns 0x77.
- WAIT_STATES=3, read PADDR=0x30 -> PREADY asserts on 4th access cycle with PSLVERR=1; a write to STATUS also gives PSLVERR=1 and leaves STATUS unchanged.
- PRESETN pulsed low during an access with FIFOs holding 2 bytes and RX_OVF=1 -> PREADY=0; STATUS read after reset = 0x04.
